req_sequencer: RTL and testbench

- Upstream request source for the serial protocol handshake FSM.
- Queues request pulses from control logic and drives the level-sensitive `req` that the protocol FSM samples on its `in` input.
- Treats the FSM's one-cycle `dout` pulse as the acknowledge.
- Drops `req` after the acknowledge, holds a guard gap so the FSM can return to IDLE, and flags requests that are never acknowledged (timeout) or cannot be queued (overflow).

---
 rtl/req_seq_pkg.sv | 21 ++
 rtl/req_pending_ctr.sv | 47 ++++
 rtl/req_sequencer.sv | 145 ++++++++++++++
 tb/tb_req_sequencer.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/req_seq_pkg.sv
// Shared types and elaboration helpers for the request sequencer.
// Pure declarations: no latency, no flow control.
package req_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ASSERT   = 2'd1,
    ST_GAP_WAIT = 2'd2,
    ST_ERR      = 2'd3
  } state_e;

  function automatic bit params_legal(input int cnt_w, input int timeout, input int gap);
    return (cnt_w >= 1) && (timeout >= 2) && (gap >= 1);
  endfunction

  // Counter width for a modulus of n; never narrower than one bit.
  function automatic int cnt_bits(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/req_pending_ctr.sv
// Saturating up/down count of queued requests; count is registered, drop is same-cycle.
// An increment at full scale with no matching decrement is rejected and flagged on drop.
module req_pending_ctr #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] count,
  output logic             nonzero,
  output logic             drop
);

  localparam logic [CNT_W-1:0] MAX = '1;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    drop    = 1'b0;
    if (inc && !dec) begin
      if (count_q == MAX) begin
        drop = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end else if (dec && !inc) begin
      if (count_q != '0) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign nonzero = |count_q;

endmodule

// File: rtl/req_sequencer.sv
// Queues start pulses and drives a level req to the protocol FSM; req rises one cycle after pending goes nonzero.
// No backpressure on start: excess starts are dropped and flagged; unacked requests time out into a sticky error stall.
module req_sequencer
  import req_seq_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TIMEOUT = 16,
  parameter int GAP     = 2
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic             ack,
  input  logic             clr_err,
  output logic             req,
  output logic             busy,
  output logic [CNT_W-1:0] pending,
  output logic             done,
  output logic             timeout_err,
  output logic             overflow
);

  localparam int TO_W  = cnt_bits(TIMEOUT);
  localparam int GAP_W = cnt_bits(GAP);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP - 1);

  if (!params_legal(CNT_W, TIMEOUT, GAP)) begin : g_param_check
    $error("req_sequencer: illegal CNT_W/TIMEOUT/GAP combination");
  end

  state_e           state_q, state_d;
  logic [TO_W-1:0]  to_cnt_q, to_cnt_d;
  logic [GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             req_q, req_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             timeout_err_q, timeout_err_d;
  logic             overflow_q, overflow_d;

  logic             ack_hit;
  logic             to_hit;
  logic             cnt_dec;
  logic [CNT_W-1:0] pend_cnt;
  logic             pend_nonzero;
  logic             cnt_drop;

  req_pending_ctr #(
    .CNT_W (CNT_W)
  ) u_pending (
    .clk     (clk),
    .rstn    (rstn),
    .inc     (start),
    .dec     (cnt_dec),
    .count   (pend_cnt),
    .nonzero (pend_nonzero),
    .drop    (cnt_drop)
  );

  always_comb begin
    state_d   = state_q;
    to_cnt_d  = to_cnt_q;
    gap_cnt_d = gap_cnt_q;
    ack_hit   = 1'b0;
    to_hit    = 1'b0;
    done_d    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        to_cnt_d  = '0;
        gap_cnt_d = '0;
        if (pend_nonzero) begin
          state_d = ST_ASSERT;
        end
      end
      ST_ASSERT: begin
        // Ack takes priority over a timeout expiring in the same cycle.
        if (ack) begin
          ack_hit   = 1'b1;
          gap_cnt_d = '0;
          state_d   = ST_GAP_WAIT;
        end else if (to_cnt_q == TO_LAST) begin
          to_hit  = 1'b1;
          state_d = ST_ERR;
        end else begin
          to_cnt_d = to_cnt_q + TO_W'(1);
        end
      end
      ST_GAP_WAIT: begin
        if (gap_cnt_q == '0) begin
          done_d = 1'b1;
        end
        if (gap_cnt_q == GAP_LAST) begin
          state_d = ST_IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q + GAP_W'(1);
        end
      end
      ST_ERR: begin
        if (clr_err) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    cnt_dec = ack_hit | to_hit;
    req_d   = (state_d == ST_ASSERT);
    // Next pending count is nonzero if a start lands or the current count outlives this cycle's decrement.
    busy_d  = (state_d != ST_IDLE) || (start && !cnt_drop) || (pend_cnt > CNT_W'(cnt_dec));

    timeout_err_d = to_hit   | (timeout_err_q & ~clr_err);
    overflow_d    = cnt_drop | (overflow_q & ~clr_err);
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q       <= ST_IDLE;
      to_cnt_q      <= '0;
      gap_cnt_q     <= '0;
      req_q         <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      timeout_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      to_cnt_q      <= to_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
      req_q         <= req_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      timeout_err_q <= timeout_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign req         = req_q;
  assign busy        = busy_q;
  assign pending     = pend_cnt;
  assign done        = done_q;
  assign timeout_err = timeout_err_q;
  assign overflow    = overflow_q;

endmodule

// File: tb/tb_req_sequencer.sv
// Directed bench: closed-loop ack model, scoreboard of req-rise and done cycles, plus a narrow-counter instance.
module tb_req_sequencer;

  logic clk = 1'b0;
  initial forever #5 clk = ~clk;

  logic       rstn, start, clr_err;
  logic       ack = 1'b0;
  logic       req, busy, done, timeout_err, overflow;
  logic [3:0] pending;

  logic       rstn2, start2, clr2;
  logic       ack2 = 1'b0;
  logic       req2, busy2, done2, terr2, ovf2;
  logic [1:0] pending2;

  req_sequencer #(.CNT_W(4), .TIMEOUT(16), .GAP(2)) u_dut (
    .clk         (clk),
    .rstn        (rstn),
    .start       (start),
    .ack         (ack),
    .clr_err     (clr_err),
    .req         (req),
    .busy        (busy),
    .pending     (pending),
    .done        (done),
    .timeout_err (timeout_err),
    .overflow    (overflow)
  );

  req_sequencer #(.CNT_W(2), .TIMEOUT(16), .GAP(2)) u_dut_ovf (
    .clk         (clk),
    .rstn        (rstn2),
    .start       (start2),
    .ack         (ack2),
    .clr_err     (clr2),
    .req         (req2),
    .busy        (busy2),
    .pending     (pending2),
    .done        (done2),
    .timeout_err (terr2),
    .overflow    (ovf2)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  int ack_at      = 2;
  bit loop_en     = 1'b0;
  int run         = 0;
  int exp_rise_q[$];
  int exp_done_q[$];
  logic req_prev  = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Protocol FSM stand-in: dout pulses in the cycle after req is first seen high.
  initial forever begin
    @(posedge clk);
    #1;
    if (req === 1'b1) run++;
    else run = 0;
    ack = loop_en && (run == ack_at);
  end

  initial forever begin
    int e;
    @(negedge clk);
    if (req === 1'b1 && req_prev !== 1'b1) begin
      e = (exp_rise_q.size() != 0) ? exp_rise_q.pop_front() : -1;
      chk("req_rise_cycle", cyc, e);
    end
    if (done === 1'b1) begin
      e = (exp_done_q.size() != 0) ? exp_done_q.pop_front() : -1;
      chk("done_cycle", cyc, e);
    end
    req_prev = req;
  end

  initial begin
    int c0;
    int c1;
    rstn = 1'b0; start = 1'b0; clr_err = 1'b0;
    rstn2 = 1'b0; start2 = 1'b0; clr2 = 1'b0;
    cycles(2);
    chk("rst_req", req, 0);
    chk("rst_busy", busy, 0);
    chk("rst_pending", pending, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_overflow", overflow, 0);
    rstn = 1'b1;
    loop_en = 1'b1;
    cycles(1);

    // single request, closed loop
    c0 = cyc;
    start = 1'b1;
    exp_rise_q.push_back(c0 + 2);
    exp_done_q.push_back(c0 + 5);
    cycles(1); start = 1'b0;
    chk("single_pending_1", pending, 1);
    chk("single_req_c1", req, 0);
    chk("single_busy_c1", busy, 1);
    cycles(1); chk("single_req_c2", req, 1);
    cycles(1); chk("single_req_c3", req, 1);
    cycles(1);
    chk("single_req_c4", req, 0);
    chk("single_pending_0", pending, 0);
    chk("single_busy_gap", busy, 1);
    cycles(1);
    chk("single_done_c5", done, 1);
    chk("single_busy_c5", busy, 1);
    cycles(1);
    chk("single_busy_c6", busy, 0);
    chk("single_done_c6", done, 0);

    // burst of three
    cycles(2);
    c0 = cyc;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_rise_q.push_back(c0 + 2 + 5 * i);
      exp_done_q.push_back(c0 + 5 + 5 * i);
    end
    cycles(3); start = 1'b0;
    chk("burst_pending_3", pending, 3);
    cycles(17);
    chk("burst_pending_end", pending, 0);
    chk("burst_busy_end", busy, 0);
    chk("burst_rise_left", exp_rise_q.size(), 0);
    chk("burst_done_left", exp_done_q.size(), 0);

    // start coincident with ack at pending=2
    cycles(2);
    c0 = cyc;
    start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      exp_rise_q.push_back(c0 + 2 + 5 * i);
      exp_done_q.push_back(c0 + 5 + 5 * i);
    end
    cycles(2); start = 1'b0;
    chk("simul_pending_2", pending, 2);
    chk("simul_req", req, 1);
    cycles(1); start = 1'b1;
    cycles(1); start = 1'b0;
    chk("simul_pending_hold", pending, 2);
    cycles(1);
    chk("simul_done", done, 1);
    cycles(15);
    chk("simul_pending_end", pending, 0);
    chk("simul_busy_end", busy, 0);

    // ack lands in the last timeout cycle
    cycles(2);
    ack_at = 16;
    c0 = cyc;
    start = 1'b1;
    exp_rise_q.push_back(c0 + 2);
    exp_done_q.push_back(c0 + 19);
    cycles(1); start = 1'b0;
    cycles(16);
    chk("ackto_req_last", req, 1);
    cycles(1);
    chk("ackto_req_low", req, 0);
    chk("ackto_no_err", timeout_err, 0);
    chk("ackto_pending", pending, 0);
    cycles(3);
    chk("ackto_busy_end", busy, 0);
    ack_at = 2;

    // timeout into ERR, queued start waits for clr_err
    loop_en = 1'b0;
    cycles(1);
    c0 = cyc;
    start = 1'b1;
    exp_rise_q.push_back(c0 + 2);
    cycles(1); start = 1'b0;
    chk("to_req_c1", req, 0);
    cycles(16);
    chk("to_req_last", req, 1);
    cycles(1);
    chk("to_req_drop", req, 0);
    chk("to_err_set", timeout_err, 1);
    chk("to_pending_0", pending, 0);
    chk("to_busy_err", busy, 1);
    start = 1'b1;
    cycles(1); start = 1'b0;
    chk("to_queued", pending, 1);
    cycles(3);
    chk("to_stall_req", req, 0);
    chk("to_stall_pending", pending, 1);
    chk("to_err_sticky", timeout_err, 1);
    c1 = cyc;
    clr_err = 1'b1;
    loop_en = 1'b1;
    exp_rise_q.push_back(c1 + 2);
    exp_done_q.push_back(c1 + 5);
    cycles(1); clr_err = 1'b0;
    chk("to_err_cleared", timeout_err, 0);
    chk("to_clr_req_c1", req, 0);
    cycles(1);
    chk("to_clr_req_c2", req, 1);
    cycles(6);
    chk("to_pending_end", pending, 0);
    chk("to_busy_end", busy, 0);

    // reset in the middle of ASSERT with a backlog
    loop_en = 1'b0;
    cycles(1);
    c0 = cyc;
    start = 1'b1;
    exp_rise_q.push_back(c0 + 2);
    cycles(3); start = 1'b0;
    chk("mrst_pending_3", pending, 3);
    chk("mrst_req_hi", req, 1);
    cycles(1); rstn = 1'b0;
    cycles(1); rstn = 1'b1;
    chk("mrst_req", req, 0);
    chk("mrst_pending", pending, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_timeout_err", timeout_err, 0);
    chk("mrst_overflow", overflow, 0);
    cycles(5);
    chk("mrst_no_req", req, 0);
    loop_en = 1'b1;
    c0 = cyc;
    start = 1'b1;
    exp_rise_q.push_back(c0 + 2);
    exp_done_q.push_back(c0 + 5);
    cycles(1); start = 1'b0;
    cycles(8);
    chk("mrst_restart_pending", pending, 0);

    // overflow on the 2-bit counter instance, ack tied low
    chk("ovf_rst_pending", pending2, 0);
    chk("ovf_rst_flag", ovf2, 0);
    rstn2 = 1'b1;
    cycles(1);
    start2 = 1'b1;
    cycles(3);
    chk("ovf_pending_3", pending2, 3);
    chk("ovf_not_yet", ovf2, 0);
    cycles(1); start2 = 1'b0;
    chk("ovf_pending_sat", pending2, 3);
    chk("ovf_set", ovf2, 1);
    clr2 = 1'b1;
    cycles(1); clr2 = 1'b0;
    chk("ovf_cleared", ovf2, 0);
    cycles(12);
    chk("ovf_req_last", req2, 1);
    chk("ovf_pending_pre", pending2, 3);
    start2 = 1'b1;
    cycles(1); start2 = 1'b0;
    chk("ovf_pending_dec_inc", pending2, 3);
    chk("ovf_no_new_flag", ovf2, 0);
    chk("ovf_timeout_err", terr2, 1);
    chk("ovf_req_drop", req2, 0);
    chk("ovf_busy_err", busy2, 1);
    chk("ovf_done_quiet", done2, 0);

    chk("final_rise_left", exp_rise_q.size(), 0);
    chk("final_done_left", exp_done_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
